// File: rtl/apb_req_master_pkg.sv
// Shared encodings and constants for the APB request master and its timeout counter.
// The timeout counter is only built with APB_REQ_MASTER_TIMEOUT_EN defined.
package apb_req_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam int TIMEOUT_CYC_DEF = 255;
  localparam int TMO_W           = 16;

endpackage

// File: rtl/apb_req_master_tmo.sv
// ACCESS-phase wait counter for APB_REQ_MASTER_TIMEOUT_EN builds; hit is combinational, count is registered.
// No backpressure: clr wins over inc, hit fires on the stalled cycle that brings the count to limit.
module apb_req_master_tmo
  import apb_req_master_pkg::*;
(
  input  logic             pclk,
  input  logic             presetn,
  input  logic             clr,
  input  logic             inc,
  input  logic [TMO_W-1:0] limit,
  output logic             hit
);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + TMO_W'(1);
    end
  end

  // Only a stalled cycle can time out, so a same-cycle pready lets the transfer complete.
  assign hit = inc && ((cnt_q + TMO_W'(1)) == limit);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_req_master.sv
// Single-outstanding APB3 initiator: accept to rsp_valid in 3 cycles plus one per pready-low cycle.
// req_ready only in IDLE; response held until rsp_ready. APB_REQ_MASTER_TIMEOUT_EN adds ACCESS abort.
module apb_req_master
  import apb_req_master_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  state_e            state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  a_timeout_range: assert property (@(posedge pclk) (TIMEOUT_CYC >= 1) && (TIMEOUT_CYC <= 65535));

`ifdef APB_REQ_MASTER_TIMEOUT_EN
  logic tmo_hit;
  logic rsp_timeout_q, rsp_timeout_d;

  apb_req_master_tmo u_tmo (
    .pclk    (pclk),
    .presetn (presetn),
    .clr     (state_q == SETUP),
    .inc     ((state_q == ACCESS) && !pready),
    .limit   (TMO_W'(TIMEOUT_CYC)),
    .hit     (tmo_hit)
  );

  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
`ifdef APB_REQ_MASTER_TIMEOUT_EN
    rsp_timeout_d = rsp_timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          pwrite_d  = req_write;
          paddr_d   = req_addr;
          pwdata_d  = req_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_err_d   = pslverr;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
`ifdef APB_REQ_MASTER_TIMEOUT_EN
        else if (tmo_hit) begin
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end
`endif
      end
      RESP: begin
        // rsp_rdata deliberately keeps the last returned word.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
`ifdef APB_REQ_MASTER_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef APB_REQ_MASTER_TIMEOUT_EN
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_REQ_MASTER_TIMEOUT_EN
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

  assign req_ready = (state_q == IDLE);
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/apb_req_master.md
Name: apb_req_master

Overview:
- Single-outstanding APB initiator that converts a valid/ready request/response interface into APB3 transfers.
- Drives the peripheral-side APB slaves (timers, GPIO, etc.) from an internal command source such as a debug or DMA front-end.
- Issues one transfer at a time. Returns read data and error status on a separate response handshake.

Parameters:
- ADDR_W, 32, width of req_addr/paddr.
- DATA_W, 32, width of write/read data.
- TIMEOUT_CYC, 255, ACCESS-phase wait limit in cycles. Used only when the optional feature is compiled in; legal range 1..65535.

Ports:
- pclk  input  1  APB clock; all logic on rising edge.
- presetn  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when req_valid and req_ready are both high.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  transfer address.
- req_wdata  input  DATA_W  write data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  response consumed when rsp_valid and rsp_ready are both high.
- rsp_rdata  output  DATA_W  read data; 0 for writes.
- rsp_err  output  1  pslverr was sampled high, or the transfer timed out.
- rsp_timeout  output  1  transfer aborted by timeout.
- psel  output  1  APB select.
- penable  output  1  APB enable.
- pwrite  output  1  APB direction.
- paddr  output  ADDR_W  APB address.
- pwdata  output  DATA_W  APB write data.
- prdata  input  DATA_W  APB read data.
- pready  input  1  APB ready; tie to 1 for slaves without wait states.
- pslverr  input  1  APB error; tie to 0 if the slave has none.

Behaviour:
- State machine states: IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- Reset values: all outputs are 0 except req_ready, which is 1 because it decodes IDLE. Assertion of presetn clears all state immediately, including mid-transfer; psel drops asynchronously.
- req_ready = (state == IDLE), decoded combinationally from the state register only. It never depends on req_valid.
- IDLE: on accept, register req_write/req_addr/req_wdata into pwrite/paddr/pwdata, set psel=1 and penable=0, and go to SETUP.
- SETUP lasts exactly 1 cycle. Next state is ACCESS with penable=1.
- ACCESS:
  - While pready=0, hold psel, penable, paddr, pwrite and pwdata stable.
  - On the first cycle with pready=1:
    - capture rsp_rdata = pwrite ? 0 : prdata;
    - capture rsp_err = pslverr;
    - clear psel and penable;
    - set rsp_valid=1;
    - go to RESP.
- RESP: hold rsp_* stable until rsp_ready=1. Then clear rsp_valid, rsp_err and rsp_timeout, and return to IDLE. rsp_rdata holds its last value.
- Latency: request accept to rsp_valid is 3 cycles with zero wait states, plus 1 per pready-low cycle. Minimum issue interval is 4 cycles.
- pwrite, paddr and pwdata retain their last values after a transfer. They are not cleared.
- req_* inputs are ignored outside IDLE. rsp_ready is ignored outside RESP.
- prdata and pslverr are sampled only in ACCESS with pready=1.
- All APB outputs are driven directly from flops, with no combinational path from inputs.

Optional Feature:
- Macro: APB_REQ_MASTER_TIMEOUT_EN.
- With the macro defined:
  - A 16-bit counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When the count reaches TIMEOUT_CYC while pready is still 0, the transfer aborts: psel=penable=0, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0, next state RESP.
  - If pready=1 in the same cycle the limit is reached, the normal completion wins.
- Without the macro: ACCESS waits indefinitely, rsp_timeout is tied to 0, and no counter is synthesized.

Decomposition:
- Shared package/include apb_req_master_pkg holds:
  - the state encodings (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, RESP=2'd3);
  - the default TIMEOUT_CYC constant;
  - the timeout counter width (16).
- One sub-module, apb_req_master_tmo, holds the timeout counter with inputs clr, inc and limit, and output hit. It is instantiated only under APB_REQ_MASTER_TIMEOUT_EN.

Test Plan:
- Zero-wait write:
  - Stimulus: req write addr 0x0000_0000, data 0x0000_1234, pready=1.
  - Response: psel high in cycles 1–2 after accept, penable high in cycle 2; rsp_valid in cycle 3 with rdata 0 and err 0.
- Read with 3 wait states:
  - Stimulus: addr 0x0000_0004, prdata=0xDEAD_BEEF on the pready rise.
  - Response: penable high for 4 cycles, addr stable throughout; rsp_rdata=0xDEAD_BEEF.
- Slave error:
  - Stimulus: read with pslverr=1 at the pready cycle.
  - Response: rsp_err=1, rsp_timeout=0.
- Response backpressure:
  - Stimulus: hold rsp_ready=0 for 5 cycles while req_valid stays high.
  - Response: rsp_* stable, req_ready=0, no new psel; IDLE and req_ready=1 the cycle after rsp_ready rises.
- Reset mid-transfer:
  - Stimulus: drop presetn during ACCESS with pready=0.
  - Response: psel, penable and rsp_valid are 0 immediately; after release, req_ready=1 and the next request completes normally.
- Timeout (macro on, TIMEOUT_CYC=8):
  - Stimulus: pready held at 0.
  - Response: abort after 8 ACCESS cycles with rsp_err=1, rsp_timeout=1, rdata 0.
  - With the macro off, the same stimulus leaves the block in ACCESS indefinitely.
